// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg
// Shared definitions for the USB receive-side CRC checker:
//   - rx_state_t    : packet FSM state (IDLE, PID, DATA, DONE)
//   - CRC5/CRC16    : generator polynomials (x^N term implied) and good-packet
//                     residuals, written as register value x[N-1]..x0
//   - PID_LEN_DEF   : number of leading PID bits excluded from the CRC
package usb_rx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PID  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } rx_state_t;

    localparam logic [4:0]  CRC5_POLY      = 5'h05;
    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    localparam logic [4:0]  CRC5_RESIDUAL  = 5'h0C;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

    localparam int PID_LEN_DEF = 8;

endpackage

// File: rtl/usb_crc_lfsr.sv
// usb_crc_lfsr
// Bit-serial CRC shift register for USB CRC5/CRC16 checking.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset (register -> all-ones)
//   en             : shift din into the register this cycle
//   init           : load all-ones (has priority over en)
//   din            : serial data bit, LSB-first as received
//   crc            : current register value x[CRC_W-1]..x0
module usb_crc_lfsr #(
    parameter int          CRC_W = 16,
    parameter logic [15:0] POLY  = 16'h8005
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             en,
    input  logic             init,
    input  logic             din,
    output logic [CRC_W-1:0] crc
);

    logic             fb;
    logic [CRC_W-1:0] crc_next;

    // NOTE: every variable assigned in always_comb gets a value on every path
    // (defaults first), so no latch can be inferred.
    always_comb begin
        fb          = din ^ crc[CRC_W-1];
        crc_next    = '0;
        crc_next[0] = fb;
        for (int i = 1; i < CRC_W; i++) begin
            crc_next[i] = crc[i-1] ^ (POLY[i] & fb);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            crc <= '1;
        end else if (init) begin
            crc <= '1;
        end else if (en) begin
            crc <= crc_next;
        end
    end

endmodule

// File: rtl/usb_crc_rx_check.sv
// usb_crc_rx_check
// Receive-side USB CRC checker. Skips the PID, runs the CRC over every
// post-PID bit (payload plus CRC field), strips the trailing CRC_W bits from
// the payload stream through a CRC_W-deep delay line, and issues a one-cycle
// verdict after end-of-packet.
// Ports:
//   clock, reset_n     : clock, asynchronous active-low reset
//   in_bit, bit_valid  : received bit (LSB-first, unstuffed) and qualifier
//   eop                : end-of-packet strobe
//   abort              : discard current packet (highest priority)
//   pay_bit, pay_valid : payload bit with CRC stripped, and qualifier
//   crc_done, crc_ok   : verdict strobe (one cycle, in DONE) and verdict
//   short_err          : packet too short (or too long), valid with crc_done
//   bit_count          : post-PID bits accepted, saturating at MAX_BITS+1
module usb_crc_rx_check
    import usb_rx_pkg::*;
#(
    parameter int          CRC_W    = 16,
    parameter logic [15:0] POLY     = CRC16_POLY,
    parameter logic [15:0] RESIDUAL = CRC16_RESIDUAL,
    parameter int          PID_LEN  = PID_LEN_DEF,
    parameter int          MAX_BITS = 8192
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_bit,
    input  logic        bit_valid,
    input  logic        eop,
    input  logic        abort,
    output logic        pay_bit,
    output logic        pay_valid,
    output logic        crc_done,
    output logic        crc_ok,
    output logic        short_err,
    output logic [15:0] bit_count
);

    localparam int          PW      = $clog2(PID_LEN + 1);
    localparam logic [15:0] MAX_CNT = 16'(MAX_BITS);
    localparam logic [15:0] CRC_CNT = 16'(CRC_W);

    rx_state_t        state;
    logic [PW-1:0]    pid_cnt;
    logic [CRC_W-1:0] dly;
    logic [CRC_W-1:0] crc;

    logic        accept;     // DATA bit that enters CRC and delay line
    logic        over;       // the bit that pushes the count past MAX_BITS
    logic        crc_init;
    logic [15:0] cnt_after;  // count including this cycle's bit
    logic        short_next; // short/long verdict if eop arrives now in DATA

    always_comb begin
        accept     = (state == DATA) && bit_valid && !abort && (bit_count < MAX_CNT);
        over       = (state == DATA) && bit_valid && !abort && (bit_count == MAX_CNT);
        // Re-arm on packet start, and clear on abort or when leaving DONE.
        crc_init   = abort || (state == DONE) || ((state == IDLE) && bit_valid);
        cnt_after  = bit_count + ((accept || over) ? 16'd1 : 16'd0);
        short_next = short_err || over || (cnt_after < CRC_CNT);
    end

    usb_crc_lfsr #(
        .CRC_W (CRC_W),
        .POLY  (POLY)
    ) u_lfsr (
        .clock   (clock),
        .reset_n (reset_n),
        .en      (accept),
        .init    (crc_init),
        .din     (in_bit),
        .crc     (crc)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            pid_cnt   <= '0;
            dly       <= '0;
            bit_count <= '0;
            short_err <= 1'b0;
            pay_bit   <= 1'b0;
            pay_valid <= 1'b0;
        end else begin
            pay_valid <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                pid_cnt   <= '0;
                dly       <= '0;
                bit_count <= '0;
                short_err <= 1'b0;
                pay_bit   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bit_valid) begin
                            pid_cnt <= PW'(1);
                            if (eop) begin
                                state     <= DONE;
                                short_err <= 1'b1;
                            end else if (PID_LEN == 1) begin
                                state <= DATA;
                            end else begin
                                state <= PID;
                            end
                        end
                    end
                    PID: begin
                        if (bit_valid) begin
                            pid_cnt <= pid_cnt + PW'(1);
                        end
                        if (eop) begin
                            state     <= DONE;
                            short_err <= 1'b1;
                        end else if (bit_valid && (pid_cnt == PW'(PID_LEN - 1))) begin
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        if (accept) begin
                            dly     <= {dly[CRC_W-2:0], in_bit};
                            pay_bit <= dly[CRC_W-1];
                            // Line full before this shift: the bit falling out
                            // is payload. With eop in the same cycle the next
                            // cycle is DONE, where pay_valid must stay low.
                            pay_valid <= (bit_count >= CRC_CNT) && !eop;
                        end
                        if (accept || over) begin
                            bit_count <= cnt_after;
                        end
                        if (over) begin
                            short_err <= 1'b1;
                        end
                        if (eop) begin
                            state     <= DONE;
                            short_err <= short_next;
                        end
                    end
                    DONE: begin
                        // Verdict cycle; any bit_valid here is dropped.
                        state     <= IDLE;
                        pid_cnt   <= '0;
                        dly       <= '0;
                        bit_count <= '0;
                        short_err <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Verdict is decoded from registered state only, so it reflects the CRC
    // after the final bit (including one sent together with eop).
    assign crc_done = (state == DONE);
    assign crc_ok   = crc_done && (crc == RESIDUAL[CRC_W-1:0]) && !short_err;

endmodule

// File: doc/usb_crc_rx_check.md
USB_CRC_RX_CHECK -- requirements
Module: usb_crc_rx_check

Interface
REQ-001 SHALL have parameter CRC_W, default 16, meaning CRC width (legal values 5 or 16).
REQ-002 SHALL have parameter POLY, default 16'h8005, meaning generator polynomial without the x^CRC_W term; only the low CRC_W bits are used.
REQ-003 SHALL have parameter RESIDUAL, default 16'h800D, meaning good-packet residual as register value x[CRC_W-1]..x0; the CRC5 value is 5'h0C.
REQ-004 SHALL have parameter PID_LEN, default 8, meaning leading bits excluded from CRC.
REQ-005 SHALL have parameter MAX_BITS, default 8192, meaning maximum post-PID bit count, including CRC.
REQ-006 SHALL have ports, in order:
- clock in 1, clock;
- reset_n in 1, reset, asynchronous, active-low;
- in_bit in 1, received bit (LSB-first, already unstuffed);
- bit_valid in 1, in_bit qualifier;
- eop in 1, end-of-packet strobe;
- abort in 1, discard current packet;
- pay_bit out 1, payload bit with CRC stripped;
- pay_valid out 1, pay_bit qualifier;
- crc_done out 1, one-cycle verdict strobe;
- crc_ok out 1, verdict, valid when crc_done is high;
- short_err out 1, packet too short or too long;
- bit_count out 16, post-PID bits accepted.

Function
REQ-007 SHALL use FSM states IDLE, PID, DATA, DONE.
REQ-008 IDLE -> PID on the first bit_valid; that bit SHALL count as PID bit 0.
REQ-009 PID SHALL count bits and SHALL NOT update the CRC or delay line; it SHALL exit to DATA after PID_LEN bits.
REQ-010 The CRC register SHALL reset to all-ones on entry to PID.
- Per DATA bit: fb = in_bit ^ x[CRC_W-1]; x0 <= fb; x[i] <= x[i-1] ^ (POLY[i] & fb).
REQ-011 DATA bits SHALL also shift into a CRC_W-deep delay line.
- pay_valid SHALL be asserted the cycle after a bit_valid only once the line holds CRC_W bits; the bit shifted out is pay_bit.
- The final CRC_W bits are therefore never emitted.
REQ-012 eop in DATA SHALL go to DONE; verdict crc_ok = (crc_reg == RESIDUAL[CRC_W-1:0]) && !short_err.
REQ-013 crc_done SHALL pulse exactly one cycle in DONE; the next state is IDLE.
- The CRC register, delay line, and counters SHALL clear on the same edge.
REQ-014 short_err SHALL be set if eop arrives in PID or IDLE-after-start, or in DATA with bit_count < CRC_W.
- Such cases SHALL still produce crc_done with crc_ok=0.
REQ-015 bit_count SHALL saturate at MAX_BITS+1 and set short_err; bits beyond MAX_BITS SHALL be ignored and produce no pay_valid.
REQ-016 bit_valid and eop in the same cycle SHALL process the bit first, then the verdict; latency is one cycle to crc_done.
REQ-017 abort SHALL have priority over all inputs: next state IDLE, no crc_done, and all state cleared.
REQ-018 bit_valid in DONE SHALL be ignored.
REQ-019 pay_valid SHALL never assert in IDLE, PID, or DONE.

Reset
REQ-020 reset_n low SHALL asynchronously force IDLE, crc_reg all-ones, and the delay line and counters to zero.
- All outputs SHALL be 0 during reset.
REQ-021 Reset asserted mid-packet SHALL discard the packet with no crc_done; the first bit after release starts a new PID.

Structure
REQ-022 Package usb_rx_pkg SHALL hold:
- the FSM state enum;
- the constants CRC5_POLY=5'h05, CRC16_POLY=16'h8005, CRC5_RESIDUAL=5'h0C, CRC16_RESIDUAL=16'h800D;
- PID_LEN_DEF=8.
REQ-023 The LFSR SHALL be the sub-module usb_crc_lfsr, with parameters CRC_W and POLY and ports en, init, din, and crc.
- The FSM, delay line, and counters live in the top.

Verification
REQ-024 Zero-length DATA0: PID 8'hC3 then 16 zero bits, then eop.
- Required: crc_done=1, crc_ok=1, short_err=0, bit_count=16, no pay_valid.
REQ-025 The same packet with bit 5 of the CRC flipped SHALL give crc_done=1 and crc_ok=0.
REQ-026 CRC_W=5, RESIDUAL=5'h0C: SETUP PID 8'h2D, addr=0, endp=0, CRC5=5'b00010, then eop.
- Required: crc_ok=1 and 11 pay_valid pulses, all pay_bit=0.
REQ-027 DATA packet with a 3-bit post-PID body, then eop.
- Required: crc_done=1, crc_ok=0, short_err=1.
REQ-028 abort asserted after 20 DATA bits.
- Required: no crc_done; the subsequent zero-length DATA0 gives crc_ok=1.
REQ-029 reset_n pulsed low mid-DATA (async, off-edge).
- Required: outputs are 0 immediately; the next packet is verified correctly.
